// File: rtl/bus_store_axi_master.sv
// bus_store_axi_master
// Write-channel AXI4 master for the store path. It accepts one store request
// (a single word or a cache-line writeback) from the granted master. It then
// runs the AW, W and B handshakes and returns a one-cycle ack together with
// an error flag. Only one transaction is outstanding at a time.

module bus_store_axi_master #(
    parameter logic [3:0] AXI_ID = 4'd1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic [31:0] req_addr,
    input  logic [2:0]  req_len,
    input  logic [2:0]  req_size,
    input  logic [31:0] wr_data,
    input  logic [3:0]  wr_strb,
    output logic [2:0]  beat_idx,
    output logic        busy,
    output logic        ack,
    output logic        resp_err,
    output logic [3:0]  awid,
    output logic [31:0] awaddr,
    output logic [7:0]  awlen,
    output logic [2:0]  awsize,
    output logic [1:0]  awburst,
    output logic        awvalid,
    input  logic        awready,
    output logic [3:0]  wid,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wlast,
    output logic        wvalid,
    input  logic        wready,
    input  logic [3:0]  bid,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ADDR = 3'd1,
        DATA = 3'd2,
        RESP = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t      state_r;
    state_t      state_nxt_s;
    logic [31:0] addr_r;
    logic [2:0]  len_r;
    logic [2:0]  size_r;
    logic [2:0]  beat_r;
    logic        err_r;
    logic        last_s;
    logic        in_data_s;
    logic        unused_ok_s;

    // The B-channel ID and the low bresp bit carry no information for this master.
    assign unused_ok_s = ^{bid, bresp[0]};

    assign last_s    = (beat_r == len_r);
    assign in_data_s = (state_r == DATA);

    // State register; reset drops straight back to IDLE and abandons any transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode: each state advances only on its own handshake.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (req) begin
                    state_nxt_s = ADDR;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ADDR: begin
                if (awready) begin
                    state_nxt_s = DATA;
                end else begin
                    state_nxt_s = ADDR;
                end
            end
            DATA: begin
                if (wready && last_s) begin
                    state_nxt_s = RESP;
                end else begin
                    state_nxt_s = DATA;
                end
            end
            RESP: begin
                if (bvalid) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = RESP;
                end
            end
            DONE: begin
                // req is deliberately ignored here so a held request is not re-accepted
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Request latch, beat counter and response flag; fields stay stable while valid is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_r <= 32'h0000_0000;
            len_r  <= 3'd0;
            size_r <= 3'd0;
            beat_r <= 3'd0;
            err_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (req) begin
                        addr_r <= req_addr;
                        len_r  <= req_len;
                        size_r <= req_size;
                        beat_r <= 3'd0;
                    end
                end
                DATA: begin
                    if (wready && !last_s) begin
                        beat_r <= beat_r + 3'd1;
                    end
                end
                RESP: begin
                    if (bvalid) begin
                        err_r <= bresp[1];
                    end
                end
                DONE: begin
                    beat_r <= 3'd0;
                end
                default: begin
                    beat_r <= beat_r;
                end
            endcase
        end
    end

    assign awid     = AXI_ID;
    assign awaddr   = addr_r;
    assign awlen    = {5'b00000, len_r};
    assign awsize   = size_r;
    assign awburst  = 2'b01;
    assign awvalid  = (state_r == ADDR);

    assign wid      = AXI_ID;
    assign wvalid   = in_data_s;
    // Write payload is forwarded only while a beat is offered, so it reads zero otherwise.
    assign wdata    = in_data_s ? wr_data : 32'h0000_0000;
    assign wstrb    = in_data_s ? wr_strb : 4'h0;
    assign wlast    = in_data_s && last_s;

    assign bready   = (state_r == RESP);
    assign busy     = (state_r != IDLE);
    assign ack      = (state_r == DONE);
    assign resp_err = err_r;
    assign beat_idx = beat_r;

endmodule

// File: tb/tb_bus_store_axi_master.sv
// Directed self-checking bench for bus_store_axi_master.
// Inputs change and outputs are sampled on the falling clock edge.

module tb_bus_store_axi_master;

    logic        clk;
    logic        rst_n;
    logic        req;
    logic [31:0] req_addr;
    logic [2:0]  req_len;
    logic [2:0]  req_size;
    logic [31:0] wr_data;
    logic [3:0]  wr_strb;
    logic [2:0]  beat_idx;
    logic        busy;
    logic        ack;
    logic        resp_err;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awvalid;
    logic        awready;
    logic [3:0]  wid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    logic [31:0] base_data;
    int          total;
    int          bad;

    bus_store_axi_master dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_addr(req_addr),
        .req_len(req_len), .req_size(req_size), .wr_data(wr_data), .wr_strb(wr_strb),
        .beat_idx(beat_idx), .busy(busy), .ack(ack), .resp_err(resp_err),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
        .awburst(awburst), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid),
        .wready(wready), .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    // Source model: data for the requested beat is base + beat index.
    assign wr_data = base_data + {29'b0, beat_idx};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", tag, got, want);
        end
    endtask

    // One transaction with programmable stalls; exp_ack is the cycle of ack counted from acceptance.
    task automatic run_txn(input logic [31:0] addr, input logic [2:0] len, input logic [2:0] size,
                           input logic [31:0] base, input logic [3:0] strb, input int aw_stall,
                           input logic [15:0] w_pat, input int b_delay, input logic [1:0] resp,
                           input bit early_b, input bit hold_req, input int exp_ack);
        int aw_seen = 0;
        int aw_hs = 0;
        int w_seen = 0;
        int b_seen = 0;
        int beat = 0;
        int ack_at = 0;
        req_addr = addr; req_len = len; req_size = size;
        base_data = base; wr_strb = strb; bresp = resp;
        bvalid = early_b; req = 1'b1;
        for (int c = 1; c <= 80 && ack_at == 0; c++) begin
            @(negedge clk);
            chk("busy", busy, 1);
            if (awvalid) begin
                awready = (aw_seen >= aw_stall);
                aw_seen++;
                if (awready) aw_hs++;
                chk("awaddr", awaddr, addr);
                chk("awlen", awlen, {5'b0, len});
                chk("awsize", awsize, size);
                chk("awburst", awburst, 2'b01);
            end else begin
                awready = 1'b0;
            end
            if (wvalid) begin
                chk("beat_idx", beat_idx, beat);
                chk("wdata", wdata, base + beat);
                chk("wstrb", wstrb, strb);
                chk("wlast", wlast, (beat == len));
                wready = w_pat[w_seen];
                w_seen++;
                if (wready) beat++;
            end else begin
                wready = 1'b0;
            end
            if (bready) begin
                chk("b_after_w", beat, len + 1);
                bvalid = early_b ? 1'b1 : (b_seen >= b_delay);
                b_seen++;
            end else begin
                bvalid = early_b;
            end
            if (ack) begin
                ack_at = c;
                chk("resp_err", resp_err, resp[1]);
                chk("ack_time", c, exp_ack);
                chk("beats", beat, len + 1);
                chk("aw_hs", aw_hs, 1);
            end
        end
        if (ack_at == 0) chk("ack_timeout", 0, 1);
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
        if (!hold_req) req = 1'b0;
        @(negedge clk);
        chk("ack_pulse", ack, 0);
        chk("busy_after", busy, 0);
        chk("beat_after", beat_idx, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        total = 0; bad = 0;
        rst_n = 1'b0; req = 1'b0; req_addr = 32'h0; req_len = 3'd0; req_size = 3'd0;
        wr_strb = 4'h0; base_data = 32'h0; awready = 1'b0; wready = 1'b0;
        bid = 4'h0; bresp = 2'b00; bvalid = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_awvalid", awvalid, 0);
        chk("rst_wvalid", wvalid, 0);
        chk("rst_bready", bready, 0);
        chk("rst_ack", ack, 0);
        chk("rst_awid", awid, 4'd1);
        chk("rst_wid", wid, 4'd1);
        chk("rst_awburst", awburst, 2'b01);
        rst_n = 1'b1;
        @(negedge clk);

        // single write
        run_txn(32'h1FC0_0010, 3'd0, 3'd2, 32'hDEAD_BEEF, 4'hF, 0, 16'hFFFF, 0, 2'b00, 1'b0, 1'b0, 4);
        // 8-beat line
        run_txn(32'h0000_1000, 3'd7, 3'd2, 32'h0000_0100, 4'hF, 0, 16'hFFFF, 0, 2'b00, 1'b0, 1'b0, 11);
        // backpressure: AW 3 stalls, W 1,0,0,1,1,1, B 4 cycles late
        run_txn(32'h2000_0040, 3'd3, 3'd2, 32'hA5A5_0000, 4'h3, 3, 16'h0039, 4, 2'b00, 1'b0, 1'b0, 16);
        // error responses then a clean one
        run_txn(32'h3000_0000, 3'd0, 3'd2, 32'h1111_1111, 4'hF, 0, 16'hFFFF, 0, 2'b10, 1'b0, 1'b0, 4);
        run_txn(32'h3000_0004, 3'd0, 3'd2, 32'h2222_2222, 4'hF, 0, 16'hFFFF, 0, 2'b11, 1'b0, 1'b0, 4);
        run_txn(32'h3000_0008, 3'd0, 3'd2, 32'h3333_3333, 4'hF, 0, 16'hFFFF, 0, 2'b00, 1'b0, 1'b0, 4);
        // early B on a 2-beat burst
        run_txn(32'h4000_0000, 3'd1, 3'd2, 32'h4444_0000, 4'hC, 0, 16'hFFFF, 0, 2'b00, 1'b1, 1'b0, 5);
        // req held through DONE: second acceptance happens in the IDLE cycle after ack
        run_txn(32'h5000_0000, 3'd0, 3'd1, 32'h5555_0000, 4'h1, 0, 16'hFFFF, 0, 2'b00, 1'b0, 1'b1, 4);
        run_txn(32'h5000_0000, 3'd0, 3'd1, 32'h5555_0000, 4'h1, 0, 16'hFFFF, 0, 2'b00, 1'b0, 1'b0, 4);

        // reset during beat 3 of an 8-beat burst
        req_addr = 32'h6000_0000; req_len = 3'd7; req_size = 3'd2;
        base_data = 32'h0000_0200; wr_strb = 4'hF; bresp = 2'b00;
        awready = 1'b1; wready = 1'b1; bvalid = 1'b0; req = 1'b1;
        repeat (5) @(negedge clk);
        chk("pre_rst_beat", beat_idx, 3);
        chk("pre_rst_wvalid", wvalid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_awvalid", awvalid, 0);
        chk("mid_rst_wvalid", wvalid, 0);
        chk("mid_rst_wlast", wlast, 0);
        chk("mid_rst_bready", bready, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_ack", ack, 0);
        chk("mid_rst_beat", beat_idx, 0);
        chk("mid_rst_awaddr", awaddr, 0);
        chk("mid_rst_resp_err", resp_err, 0);
        req = 1'b0; awready = 1'b0; wready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_busy", busy, 0);
        run_txn(32'h7000_0020, 3'd0, 3'd2, 32'hCAFE_F00D, 4'hF, 0, 16'hFFFF, 0, 2'b00, 1'b0, 1'b0, 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bus_store_axi_master.md
# bus_store_axi_master

Write-channel AXI4 master for the store path. It sits directly downstream of the store-bus arbiter and its grant-driven request mux. It accepts one store request from the currently granted master (single word or cache-line writeback), then drives the AXI AW, W and B channels to completion. It returns a one-cycle `ack` with an error flag. Only one transaction is outstanding at a time.

## Interface
Parameters:
- `AXI_ID`, default 4'd1: constant driven on `awid` and `wid`.

Ports:
- `clk`  in  1  clock; everything is rising-edge.
- `rst_n`  in  1  reset; **asynchronous, active-low**.
- `req`  in  1  store request from the granted master; level, held until `ack`.
- `req_addr`  in  32  start byte address; passed unmodified to `awaddr`.
- `req_len`  in  3  beats minus 1 (0 = single word, 7 = 8-word line).
- `req_size`  in  3  AXI size code for `awsize`.
- `wr_data`  in  32  data for beat `beat_idx`, presented combinationally by the source.
- `wr_strb`  in  4  byte strobes for beat `beat_idx`.
- `beat_idx`  out  3  index of the current W beat.
- `busy`  out  1  high from acceptance through the `ack` cycle; upstream must not change the granted master while it is high.
- `ack`  out  1  one-cycle completion pulse.
- `resp_err`  out  1  valid with `ack`; 1 when `bresp[1]` = 1 (SLVERR or DECERR).
- `awid`/`awaddr`/`awlen`/`awsize`/`awburst`/`awvalid`  out  4/32/8/3/2/1  AW channel. `awlen` = {5'b0, len}; `awburst` = 2'b01 (INCR).
- `awready`  in  1.
- `wid`/`wdata`/`wstrb`/`wlast`/`wvalid`  out  4/32/4/1/1  W channel.
- `wready`  in  1.
- `bid`  in  4  ignored (not checked).
- `bresp`  in  2.
- `bvalid`  in  1.
- `bready`  out  1.

## Operation
- FSM has five states: IDLE, ADDR, DATA, RESP, DONE.
- **IDLE**: when `req` = 1, latch `req_addr`, `req_len` and `req_size`, clear the beat counter, and go to ADDR.
- **ADDR**: `awvalid` = 1 with the latched fields. On `awvalid & awready`, go to DATA.
- **DATA**: `wvalid` = 1, `wdata` = `wr_data`, `wstrb` = `wr_strb`.
  - `wlast` = 1 when `beat_idx` equals the latched len.
  - On `wvalid & wready & !wlast`, increment `beat_idx`.
  - On `wvalid & wready & wlast`, go to RESP.
- **RESP**: `bready` = 1. On `bvalid`, register `resp_err` = `bresp[1]` and go to DONE.
- **DONE**: `ack` = 1 for this single cycle, `beat_idx` returns to 0, and the FSM goes to IDLE. `req` is ignored in DONE, so a request still high cannot be re-accepted.
- Output values by state:
  - `awvalid` is high only in ADDR.
  - `wvalid` is high only in DATA.
  - `bready` is high only in RESP.
  - `busy` is high in every state except IDLE.
- AXI stability: while `awvalid` or `wvalid` is high without ready, the corresponding payload must not change. The latched AW fields guarantee this for AW. For W, `beat_idx` advances only on handshake, and upstream keeps the source stable while `busy` is high.
- `bvalid` arriving before the last W handshake is not accepted, because `bready` is low outside RESP.
- A `req` change while `busy` is high has no effect.
- On reset, including mid-transaction, the FSM goes to IDLE immediately (asynchronously). No handshake is completed and the in-flight transaction is abandoned.
  - Every output returns to 0, except the constants `awid`, `wid` and `awburst`.
  - `beat_idx` = 0 and `resp_err` = 0.

## Timing
- All outputs are decoded from registered state and counters, except `wdata`/`wstrb`, which pass straight through from `wr_data`/`wr_strb`.
- With `req` sampled at cycle T and all readies and `bvalid` high, a single beat completes as follows:
  - T+1: `awvalid`
  - T+2: `wvalid` + `wlast`
  - T+3: `bready`
  - T+4: `ack`
  - T+5: IDLE, ready to accept.
- An 8-beat burst under the same conditions produces `ack` at T+11.
- Each cycle `awready` is low adds one cycle to ADDR. Each cycle `wready` is low holds the current beat. Each cycle `bvalid` is low extends RESP.
- Minimum spacing between two accepted requests is 5 cycles.

## Test plan
- **Single write**: `req_addr`=0x1FC0_0010, len=0, `wr_strb`=4'hF, `wr_data`=0xDEADBEEF, all readies and `bvalid` high, `bresp`=0.
  - Expect `awlen`=0, `awburst`=01, `wlast` on the only beat, `ack` at T+4, `resp_err`=0.
- **8-beat line**: len=7, source returns `wr_data`=0x100+`beat_idx`.
  - Expect 8 W beats carrying 0x100..0x107, `wlast` only on beat 7, `ack` at T+11, `beat_idx` back to 0.
- **Backpressure**: `awready` low 3 cycles; `wready` toggling 1,0,0,1 on a 4-beat burst; `bvalid` delayed 4 cycles.
  - Expect `awaddr`, `wdata` and `wstrb` stable while valid is high, no beat skipped or duplicated, exactly one `ack`.
- **Error response**: `bresp`=2'b10, then a second run with `bresp`=2'b11.
  - Expect `resp_err`=1 coincident with `ack` in both runs. A following request with `bresp`=0 gives `resp_err`=0.
- **Early B and held req**:
  - `bvalid` high from T+1: expect `bready` low until RESP and completion only after `wlast`.
  - `req` held high through DONE: exactly one transaction and one `ack`, next acceptance at T+5.
- **Reset mid-burst**: assert `rst_n`=0 during beat 3 of an 8-beat burst.
  - Expect `awvalid`, `wvalid`, `bready`, `busy` and `ack` to go to 0 asynchronously and `beat_idx`=0. After release, a new single write completes normally.
